// File: rtl/vga_mem_arbiter.sv
// Round-robin arbiter that shares one synchronous character-memory read port
// among NREQ pixel-pipeline requesters. The read latency is a fixed 2 cycles.
module vga_mem_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 8,
    parameter int DW   = 8
) (
    input  logic                 px_clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    output logic [NREQ-1:0]      gnt,
    output logic [AW-1:0]        mem_addr,
    input  logic [DW-1:0]        mem_din,
    output logic [NREQ-1:0]      rvalid,
    output logic [DW-1:0]        rdata
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]   r_ptr;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_rvalid;
    logic [AW-1:0]   r_mem_addr;

    logic [NREQ-1:0] w_busy;
    logic [NREQ-1:0] w_elig;
    logic            w_any;
    logic [PW-1:0]   w_win;
    logic [PW-1:0]   w_cand;

    // A requester is busy only during its grant cycle; once its rvalid cycle
    // is under way it may win again at the edge that closes that cycle.
    assign w_busy = r_gnt;
    assign w_elig = req & ~w_busy & {NREQ{en}};

    // Scan ptr, ptr+1, ... ; the PW-bit add wraps naturally for NREQ=4.
    always_comb begin
        w_any  = 1'b0;
        w_win  = '0;
        w_cand = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = r_ptr + PW'(k);
            if (!w_any && w_elig[w_cand]) begin
                w_any = 1'b1;
                w_win = w_cand;
            end
        end
    end

    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            r_ptr      <= '0;
            r_gnt      <= '0;
            r_rvalid   <= '0;
            r_mem_addr <= '0;
        end else begin
            r_rvalid <= r_gnt;
            if (w_any) begin
                r_gnt      <= NREQ'(1) << w_win;
                // Only the winner's slice is muxed, so idle slices never leak.
                r_mem_addr <= req_addr[w_win*AW +: AW];
                r_ptr      <= w_win + PW'(1);
            end else begin
                r_gnt <= '0;
            end
        end
    end

    assign gnt      = r_gnt;
    assign rvalid   = r_rvalid;
    assign mem_addr = r_mem_addr;
    assign rdata    = (|r_rvalid) ? mem_din : '0;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Directed and randomized checks of vga_mem_arbiter against a behavioural
// memory and an independent round-robin reference.
module tb_vga_mem_arbiter;

    logic        px_clk;
    logic        reset;
    logic        en;
    logic [3:0]  req;
    logic [31:0] req_addr;
    logic [3:0]  gnt;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_din;
    logic [3:0]  rvalid;
    logic [7:0]  rdata;

    int errors = 0;
    int checks = 0;

    vga_mem_arbiter #(.NREQ(4), .AW(8), .DW(8)) dut (
        .px_clk   (px_clk),
        .reset    (reset),
        .en       (en),
        .req      (req),
        .req_addr (req_addr),
        .gnt      (gnt),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .rvalid   (rvalid),
        .rdata    (rdata)
    );

    initial px_clk = 1'b0;
    always #5 px_clk = ~px_clk;

    function automatic logic [7:0] memval(input logic [7:0] a);
        return (a == 8'h5A) ? 8'hC3 : (a ^ 8'h3C);
    endfunction

    // Synchronous-read character memory model.
    always @(posedge px_clk) mem_din <= memval(mem_addr);

    task automatic tick;
        @(posedge px_clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; req = 4'hF; en = 1'b1; req_addr = 32'h0;
        repeat (3) tick;
        checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL rst_gnt: got %b exp %b", gnt, 4'b0); end
        checks++; if (rvalid !== 4'b0) begin errors++; $display("FAIL rst_rvalid: got %b exp %b", rvalid, 4'b0); end
        checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL rst_mem_addr: got %h exp %h", mem_addr, 8'h00); end
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata: got %h exp %h", rdata, 8'h00); end
        reset = 1'b0; req = 4'h0;
        tick;
        checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL rst_idle_gnt: got %b exp %b", gnt, 4'b0); end
    endtask

    task automatic test_round_robin;
        logic [3:0] eg, er;
        logic [7:0] ea, erd;
        req_addr = {8'h13, 8'h12, 8'h11, 8'h10};
        req = 4'hF; en = 1'b1;
        for (int n = 0; n < 8; n++) begin
            tick;
            eg  = 4'(1 << (n % 4));
            ea  = 8'(16 + n % 4);
            er  = (n == 0) ? 4'b0 : 4'(1 << ((n - 1) % 4));
            erd = (n == 0) ? 8'h00 : memval(8'(16 + (n - 1) % 4));
            checks++; if (gnt !== eg) begin errors++; $display("FAIL rr_gnt[%0d]: got %b exp %b", n, gnt, eg); end
            checks++; if (mem_addr !== ea) begin errors++; $display("FAIL rr_addr[%0d]: got %h exp %h", n, mem_addr, ea); end
            checks++; if (rvalid !== er) begin errors++; $display("FAIL rr_rvalid[%0d]: got %b exp %b", n, rvalid, er); end
            checks++; if (rdata !== erd) begin errors++; $display("FAIL rr_rdata[%0d]: got %h exp %h", n, rdata, erd); end
        end
        req = 4'h0;
        tick;
        checks++; if (rvalid !== 4'b1000) begin errors++; $display("FAIL rr_last_rvalid: got %b exp %b", rvalid, 4'b1000); end
        tick;
    endtask

    task automatic test_single;
        req_addr = 32'hxx5Axxxx;
        req = 4'b0100; en = 1'b1;
        tick;
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt: got %b exp %b", gnt, 4'b0100); end
        checks++; if (mem_addr !== 8'h5A) begin errors++; $display("FAIL single_addr: got %h exp %h", mem_addr, 8'h5A); end
        checks++; if (rvalid !== 4'b0) begin errors++; $display("FAIL single_rvalid_early: got %b exp %b", rvalid, 4'b0); end
        req = 4'h0;
        tick;
        checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL single_gnt_off: got %b exp %b", gnt, 4'b0); end
        checks++; if (rvalid !== 4'b0100) begin errors++; $display("FAIL single_rvalid: got %b exp %b", rvalid, 4'b0100); end
        checks++; if (rdata !== 8'hC3) begin errors++; $display("FAIL single_rdata: got %h exp %h", rdata, 8'hC3); end
        tick;
        checks++; if (rvalid !== 4'b0) begin errors++; $display("FAIL single_rvalid_off: got %b exp %b", rvalid, 4'b0); end
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL single_rdata_off: got %h exp %h", rdata, 8'h00); end
        checks++; if (mem_addr !== 8'h5A) begin errors++; $display("FAIL single_addr_hold: got %h exp %h", mem_addr, 8'h5A); end
        req_addr = 32'h0;
    endtask

    task automatic test_wrap;
        // Grant requester 2 alone so the pointer sits at 3.
        req_addr = 32'h0; req = 4'b0100; en = 1'b1;
        tick;
        req = 4'h0;
        tick; tick;
        req_addr = {8'h23, 8'h22, 8'h21, 8'h20};
        req = 4'b1001;
        tick;
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL wrap_gnt3: got %b exp %b", gnt, 4'b1000); end
        checks++; if (mem_addr !== 8'h23) begin errors++; $display("FAIL wrap_addr3: got %h exp %h", mem_addr, 8'h23); end
        tick;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wrap_gnt0: got %b exp %b", gnt, 4'b0001); end
        checks++; if (mem_addr !== 8'h20) begin errors++; $display("FAIL wrap_addr0: got %h exp %h", mem_addr, 8'h20); end
        checks++; if (rdata !== 8'h1F) begin errors++; $display("FAIL wrap_rdata3: got %h exp %h", rdata, 8'h1F); end
        req = 4'h0;
        tick;
        checks++; if (rvalid !== 4'b0001) begin errors++; $display("FAIL wrap_rvalid0: got %b exp %b", rvalid, 4'b0001); end
        checks++; if (rdata !== 8'h1C) begin errors++; $display("FAIL wrap_rdata0: got %h exp %h", rdata, 8'h1C); end
        // Pointer is now 1: of {0,3}, 3 comes first in the scan.
        req = 4'b1001;
        tick;
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL wrap_ptr1: got %b exp %b", gnt, 4'b1000); end
        req = 4'h0;
        tick; tick;
    endtask

    task automatic test_en_drop;
        req_addr = {8'h33, 8'h32, 8'h31, 8'h30};
        req = 4'hF; en = 1'b1;
        tick;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL en_gnt: got %b exp %b", gnt, 4'b0001); end
        en = 1'b0;
        tick;
        checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL en_blocked: got %b exp %b", gnt, 4'b0); end
        checks++; if (rvalid !== 4'b0001) begin errors++; $display("FAIL en_rvalid: got %b exp %b", rvalid, 4'b0001); end
        checks++; if (rdata !== 8'h0C) begin errors++; $display("FAIL en_rdata: got %h exp %h", rdata, 8'h0C); end
        for (int n = 0; n < 2; n++) begin
            tick;
            checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL en_idle_gnt[%0d]: got %b exp %b", n, gnt, 4'b0); end
            checks++; if (mem_addr !== 8'h30) begin errors++; $display("FAIL en_addr_hold[%0d]: got %h exp %h", n, mem_addr, 8'h30); end
        end
        en = 1'b1;
        tick;
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL en_ptr_held: got %b exp %b", gnt, 4'b0010); end
        checks++; if (mem_addr !== 8'h31) begin errors++; $display("FAIL en_addr1: got %h exp %h", mem_addr, 8'h31); end
        req = 4'h0;
        tick; tick;
    endtask

    task automatic test_reset_mid;
        req_addr = {8'h43, 8'h42, 8'h41, 8'h40};
        req = 4'b0010; en = 1'b1;
        tick;
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL mid_gnt: got %b exp %b", gnt, 4'b0010); end
        reset = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL mid_gnt_clr: got %b exp %b", gnt, 4'b0); end
        checks++; if (rvalid !== 4'b0) begin errors++; $display("FAIL mid_rvalid_clr: got %b exp %b", rvalid, 4'b0); end
        checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL mid_addr_clr: got %h exp %h", mem_addr, 8'h00); end
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL mid_rdata_clr: got %h exp %h", rdata, 8'h00); end
        req = 4'h0;
        tick;
        reset = 1'b0;
        for (int n = 0; n < 2; n++) begin
            tick;
            checks++; if (rvalid !== 4'b0) begin errors++; $display("FAIL mid_no_rvalid[%0d]: got %b exp %b", n, rvalid, 4'b0); end
        end
        // Pre-reset pointer was 2 and would pick 3; reset makes 0 first.
        req = 4'b1001;
        tick;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL mid_prio0: got %b exp %b", gnt, 4'b0001); end
        req = 4'h0;
        tick; tick;
    endtask

    task automatic test_random;
        logic [3:0] rq, pg, eg;
        logic [7:0] pa, ea, erd;
        int mptr, w, idx, mx;
        bit found;
        int wt[4];
        reset = 1'b1; req = 4'h0; en = 1'b0;
        tick;
        reset = 1'b0;
        tick;
        rq = 4'h0; pg = 4'h0; pa = 8'h00; mptr = 0;
        for (int i = 0; i < 4; i++) wt[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 4; i++) if ($urandom_range(7) == 0) rq[i] = ~rq[i];
            req = rq;
            en = ($urandom_range(7) != 0);
            req_addr = $urandom;
            found = 1'b0; w = 0; eg = 4'h0; ea = pa;
            for (int k = 0; k < 4; k++) begin
                idx = (mptr + k) % 4;
                if (!found && rq[idx] && !pg[idx] && en) begin found = 1'b1; w = idx; end
            end
            if (found) begin
                eg = 4'(1 << w);
                ea = req_addr[w*8 +: 8];
                mptr = (w + 1) % 4;
            end
            erd = (pg != 4'h0) ? memval(pa) : 8'h00;
            tick;
            checks++; if (gnt !== eg) begin errors++; $display("FAIL rnd_gnt[%0d]: got %b exp %b", c, gnt, eg); end
            checks++; if (mem_addr !== ea) begin errors++; $display("FAIL rnd_addr[%0d]: got %h exp %h", c, mem_addr, ea); end
            checks++; if (rvalid !== pg) begin errors++; $display("FAIL rnd_rvalid[%0d]: got %b exp %b", c, rvalid, pg); end
            checks++; if (rdata !== erd) begin errors++; $display("FAIL rnd_rdata[%0d]: got %h exp %h", c, rdata, erd); end
            checks++; if (!$onehot0(gnt) || !$onehot0(rvalid)) begin errors++; $display("FAIL rnd_onehot[%0d]: got gnt=%b rvalid=%b exp one-hot or zero", c, gnt, rvalid); end
            checks++; if ((gnt & rvalid) !== 4'h0) begin errors++; $display("FAIL rnd_early_regrant[%0d]: got gnt=%b rvalid=%b exp no overlap", c, gnt, rvalid); end
            mx = 0;
            for (int i = 0; i < 4; i++) begin
                if (!rq[i] || gnt[i]) wt[i] = 0;
                else if (gnt != 4'h0) wt[i]++;
                if (wt[i] > mx) mx = wt[i];
            end
            checks++; if (mx > 3) begin errors++; $display("FAIL rnd_starve[%0d]: got %0d other grants exp at most 3", c, mx); end
            pg = eg;
            pa = ea;
        end
        req = 4'h0; en = 1'b0;
        tick; tick;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; req = 4'h0; req_addr = 32'h0;
        test_reset;
        test_round_robin;
        test_single;
        test_wrap;
        test_en_drop;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
